// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and reference digests for the SHA3-256
// absorb controller.
package sha3_pkg;

  localparam int RATE_WORDS = 34;
  localparam int WORD_W     = 32;
  localparam int DIGEST_W   = 256;
  localparam int RATE_BYTES = 136;
  localparam int BLOCK_W    = RATE_WORDS * WORD_W;

  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  localparam logic [DIGEST_W-1:0] SHA3_256_EMPTY =
    256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
  localparam logic [DIGEST_W-1:0] SHA3_256_ABC =
    256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/sha3_absorb_ctrl_if.sv
// Message-stream, core-handshake and status signals of the absorb controller,
// named from the controller's point of view.
interface sha3_absorb_ctrl_if;
  import sha3_pkg::*;

  logic                msg_valid_i;
  logic                msg_ready_o;
  logic [WORD_W-1:0]   msg_data_i;
  logic                msg_last_i;
  logic [2:0]          msg_bytes_i;
  logic                abort_i;

  logic                core_start_o;
  logic                core_first_o;
  logic [BLOCK_W-1:0]  core_block_o;
  logic                core_done_i;
  logic [DIGEST_W-1:0] core_digest_i;

  logic [DIGEST_W-1:0] digest_o;
  logic                digest_valid_o;
  logic                busy_o;
  logic [15:0]         blocks_o;

  modport slave (
    input  msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i, abort_i,
    input  core_done_i, core_digest_i,
    output msg_ready_o, core_start_o, core_first_o, core_block_o,
    output digest_o, digest_valid_o, busy_o, blocks_o
  );

  modport master (
    output msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i, abort_i,
    output core_done_i, core_digest_i,
    input  msg_ready_o, core_start_o, core_first_o, core_block_o,
    input  digest_o, digest_valid_o, busy_o, blocks_o
  );

endinterface

// File: rtl/sha3_pad_insert.sv
// Combinational SHA-3 padding: ORs the domain byte in at pad_pos_i and the
// end marker into the last rate byte.
module sha3_pad_insert
  import sha3_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [7:0]         pad_pos_i,
  output logic [BLOCK_W-1:0] block_o
);

  always_comb begin
    block_o = block_i;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (pad_pos_i == 8'(i)) begin
        block_o[8*i +: 8] = block_i[8*i +: 8] | PAD_DS;
      end
    end
    block_o[BLOCK_W-1 -: 8] = block_o[BLOCK_W-1 -: 8] | PAD_END;
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Packs a 32-bit message stream into padded 1088-bit rate blocks, issues one
// core start per block and captures the SHA3-256 digest after the last one.
module sha3_absorb_ctrl
  import sha3_pkg::*;
(
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  sha3_absorb_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [BLOCK_W-1:0]  buf_q, buf_d, padded;
  logic [5:0]          wordCnt_q, wordCnt_d;
  logic [7:0]          padPos_q, padPos_d;
  logic                finalBlk_q, finalBlk_d;
  logic                padOnly_q, padOnly_d;
  logic                first_q, first_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                digestValid_q, digestValid_d;
  logic [15:0]         blocks_q, blocks_d;

  logic                msgReady;
  logic                accept;
  logic [5:0]          slot;
  logic [WORD_W-1:0]   wordMasked;

  sha3_pad_insert uPad (
    .block_i   (buf_q),
    .pad_pos_i (padPos_q),
    .block_o   (padded)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      wordCnt_q     <= '0;
      padPos_q      <= '0;
      finalBlk_q    <= 1'b0;
      padOnly_q     <= 1'b0;
      first_q       <= 1'b1;
      digest_q      <= '0;
      digestValid_q <= 1'b0;
      blocks_q      <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      wordCnt_q     <= wordCnt_d;
      padPos_q      <= padPos_d;
      finalBlk_q    <= finalBlk_d;
      padOnly_q     <= padOnly_d;
      first_q       <= first_d;
      digest_q      <= digest_d;
      digestValid_q <= digestValid_d;
      blocks_q      <= blocks_d;
    end
  end

  // A word that arrives together with abort is dropped.
  assign accept = bus.msg_valid_i && msgReady && !bus.abort_i;
  assign slot   = (state_q == ST_FILL) ? wordCnt_q : 6'd0;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wordMasked[8*b +: 8] = (!bus.msg_last_i || (3'(b) < bus.msg_bytes_i)) ?
                             bus.msg_data_i[8*b +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    wordCnt_d     = wordCnt_q;
    padPos_d      = padPos_q;
    finalBlk_d    = finalBlk_q;
    padOnly_d     = padOnly_q;
    first_d       = first_q;
    digest_d      = digest_q;
    digestValid_d = digestValid_q;
    blocks_d      = blocks_q;

    if (bus.abort_i) begin
      buf_d         = '0;
      wordCnt_d     = '0;
      digestValid_d = 1'b0;
      blocks_d      = '0;
      finalBlk_d    = 1'b0;
      padOnly_d     = 1'b0;
      first_d       = 1'b1;
      // The core is still permuting in WAIT/DRAIN, so its done must be swallowed.
      state_d       = (state_q == ST_WAIT || state_q == ST_DRAIN) ? ST_DRAIN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_FILL: begin
          if (accept) begin
            if (state_q != ST_FILL) begin
              buf_d         = '0;
              digestValid_d = 1'b0;
              blocks_d      = '0;
              first_d       = 1'b1;
              finalBlk_d    = 1'b0;
              padOnly_d     = 1'b0;
            end
            buf_d[WORD_W*slot +: WORD_W] = wordMasked;
            wordCnt_d = slot + 6'd1;
            if (bus.msg_last_i) begin
              padPos_d = {slot, 2'b00} + {5'b0, bus.msg_bytes_i};
              state_d  = ST_PAD;
            end else if (slot == 6'(RATE_WORDS - 1)) begin
              finalBlk_d = 1'b0;
              state_d    = ST_START;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        ST_PAD: begin
          if (padPos_q < 8'(RATE_BYTES)) begin
            buf_d      = padded;
            finalBlk_d = 1'b1;
            padOnly_d  = 1'b0;
          end else begin
            finalBlk_d = 1'b0;
            padOnly_d  = 1'b1;
          end
          state_d = ST_START;
        end
        ST_START: begin
          first_d = 1'b0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.core_done_i) begin
            if (blocks_q != 16'hFFFF) begin
              blocks_d = blocks_q + 16'd1;
            end
            if (finalBlk_q) begin
              digest_d      = bus.core_digest_i;
              digestValid_d = 1'b1;
              state_d       = ST_DONE;
            end else if (padOnly_q) begin
              buf_d                   = '0;
              buf_d[7:0]              = PAD_DS;
              buf_d[BLOCK_W-1 -: 8]   = PAD_END;
              padOnly_d               = 1'b0;
              finalBlk_d              = 1'b1;
              state_d                 = ST_START;
            end else begin
              buf_d     = '0;
              wordCnt_d = '0;
              state_d   = ST_FILL;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.core_done_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    msgReady         = 1'b0;
    bus.core_start_o = 1'b0;
    bus.core_first_o = 1'b0;
    bus.busy_o       = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        msgReady   = 1'b1;
        bus.busy_o = 1'b0;
      end
      ST_FILL: msgReady = 1'b1;
      ST_START: begin
        bus.core_start_o = 1'b1;
        bus.core_first_o = first_q;
      end
      default: ;
    endcase
  end

  assign bus.msg_ready_o    = msgReady;
  assign bus.core_block_o   = buf_q;
  assign bus.digest_o       = digest_q;
  assign bus.digest_valid_o = digestValid_q;
  assign bus.blocks_o       = blocks_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Self-checking bench: byte-level SHA-3 padding model plus a stub core that
// records every started block and answers with a chosen digest.
module tb_sha3_absorb_ctrl;
  import sha3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_absorb_ctrl_if bus();

  sha3_absorb_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;
  int lastDoneCycle = 0;
  int pending = 0;
  int coreDelay = 0;
  bit abortMode = 1'b0;

  logic [7:0]          msgQ[$];
  logic [BLOCK_W-1:0]  expBlocks[$];
  logic [BLOCK_W-1:0]  gotBlocks[$];
  bit                  gotFirst[$];
  logic [DIGEST_W-1:0] coreDigest = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    testCount++;
    failCount++;
    $error("[TB] FAIL %s: bound expired waiting for DUT", tag);
  endtask

  function automatic logic [255:0] chunk(input logic [BLOCK_W-1:0] blk, input int c);
    logic [255:0] r;
    if (c < 4) r = blk[256*c +: 256];
    else       r = {192'd0, blk[BLOCK_W-1 -: 64]};
    return r;
  endfunction

  // Stub permutation core: latches the block at start, answers after a delay.
  initial begin
    bus.core_done_i   = 1'b0;
    bus.core_digest_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending         = 0;
        bus.core_done_i = 1'b0;
      end else begin
        bus.core_done_i = 1'b0;
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            bus.core_done_i   = 1'b1;
            bus.core_digest_i = coreDigest;
            lastDoneCycle     = cycle;
            if (!abortMode) begin
              checkOutput("block stable until done",
                          {255'd0, bus.core_block_o === gotBlocks[gotBlocks.size()-1]}, 256'd1);
              checkOutput("ready low in WAIT", {255'd0, bus.msg_ready_o}, 256'd0);
            end
          end
        end
        if (bus.core_start_o) begin
          checkOutput("start only when core idle", 256'(pending), 256'd0);
          gotBlocks.push_back(bus.core_block_o);
          gotFirst.push_back(bus.core_first_o);
          pending = (coreDelay > 0) ? coreDelay : int'($urandom_range(1, 5));
        end
      end
    end
  end

  // Reference padding: message bytes, 0x06 after them, 0x80 in the last rate byte.
  task automatic buildExpected();
    int len;
    int nb;
    logic [7:0] padded[$];
    logic [BLOCK_W-1:0] blk;
    len = msgQ.size();
    nb  = len / RATE_BYTES + 1;
    expBlocks.delete();
    for (int i = 0; i < nb * RATE_BYTES; i++) padded.push_back(i < len ? msgQ[i] : 8'h00);
    padded[len] = padded[len] | PAD_DS;
    padded[nb*RATE_BYTES-1] = padded[nb*RATE_BYTES-1] | PAD_END;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < RATE_BYTES; k++) blk[8*k +: 8] = padded[b*RATE_BYTES + k];
      expBlocks.push_back(blk);
    end
  endtask

  task automatic sendWord(input logic [31:0] d, input bit last, input logic [2:0] nb);
    int n = 0;
    bus.msg_valid_i = 1'b1;
    bus.msg_data_i  = d;
    bus.msg_last_i  = last;
    bus.msg_bytes_i = nb;
    while (!bus.msg_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeoutFail("word accept");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fillRandom(input int len);
    msgQ.delete();
    for (int i = 0; i < len; i++) msgQ.push_back(8'($urandom));
  endtask

  task automatic applyStimulus(input string name, input logic [255:0] dig, input bit extraEmpty);
    int len;
    int nw;
    int lastBytes;
    int nExp;
    int n;
    logic [31:0] w;
    logic [255:0] firstObs;
    logic [255:0] firstExp;
    bit isLast;

    coreDigest = dig;
    gotBlocks.delete();
    gotFirst.delete();
    buildExpected();
    nExp = expBlocks.size();
    len  = msgQ.size();

    if (extraEmpty || len == 0) begin
      nw = len / 4;
      lastBytes = 4;
    end else begin
      nw = (len + 3) / 4;
      lastBytes = len - 4 * (nw - 1);
    end
    for (int wi = 0; wi < nw; wi++) begin
      for (int k = 0; k < 4; k++) begin
        w[8*k +: 8] = (4*wi + k < len) ? msgQ[4*wi + k] : 8'($urandom);
      end
      isLast = (wi == nw - 1) && !extraEmpty;
      sendWord(w, isLast, isLast ? 3'(lastBytes) : 3'd4);
    end
    if (extraEmpty || len == 0) sendWord($urandom, 1'b1, 3'd0);
    bus.msg_valid_i = 1'b0;

    checkOutput({name, " start low in PAD"}, {255'd0, bus.core_start_o}, 256'd0);
    @(negedge clk);
    checkOutput({name, " start 2 cycles after last"}, {255'd0, bus.core_start_o}, 256'd1);

    n = 0;
    while (!bus.digest_valid_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) timeoutFail({name, " digest_valid"});

    checkOutput({name, " digest"}, bus.digest_o, dig);
    checkOutput({name, " done->valid latency"}, 256'(cycle - lastDoneCycle), 256'd1);
    checkOutput({name, " blocks_o"}, 256'(bus.blocks_o), 256'(nExp));
    checkOutput({name, " start count"}, 256'(gotBlocks.size()), 256'(nExp));
    for (int b = 0; b < nExp && b < gotBlocks.size(); b++) begin
      for (int c = 0; c < 5; c++) begin
        checkOutput($sformatf("%s blk%0d chunk%0d", name, b, c),
                    chunk(gotBlocks[b], c), chunk(expBlocks[b], c));
      end
    end
    firstObs = '0;
    firstExp = 256'd1;
    for (int b = 0; b < gotFirst.size() && b < 256; b++) firstObs[b] = gotFirst[b];
    checkOutput({name, " core_first pattern"}, firstObs, firstExp);
    checkOutput({name, " busy after done"}, {255'd0, bus.busy_o}, 256'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit sawStart;

    bus.msg_valid_i = 1'b0;
    bus.msg_data_i  = '0;
    bus.msg_last_i  = 1'b0;
    bus.msg_bytes_i = '0;
    bus.abort_i     = 1'b0;

    #1;
    checkOutput("reset busy", {255'd0, bus.busy_o}, 256'd0);
    checkOutput("reset start", {255'd0, bus.core_start_o}, 256'd0);
    checkOutput("reset digest_valid", {255'd0, bus.digest_valid_o}, 256'd0);
    checkOutput("reset blocks", 256'(bus.blocks_o), 256'd0);
    checkOutput("reset digest", bus.digest_o, 256'd0);
    checkOutput("reset block", chunk(bus.core_block_o, 0), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    msgQ.delete();
    applyStimulus("empty", SHA3_256_EMPTY, 1'b0);

    msgQ.delete();
    msgQ.push_back(8'h61);
    msgQ.push_back(8'h62);
    msgQ.push_back(8'h63);
    applyStimulus("abc", SHA3_256_ABC, 1'b0);

    fillRandom(135);
    applyStimulus("len135", {8{$urandom}}, 1'b0);

    fillRandom(136);
    applyStimulus("len136", {8{$urandom}}, 1'b0);

    fillRandom(300);
    applyStimulus("len300", {8{$urandom}}, 1'b0);

    fillRandom(8);
    applyStimulus("len8 empty tail", {8{$urandom}}, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fillRandom(int'($urandom_range(1, 420)));
      applyStimulus($sformatf("rand%0d len%0d", r, msgQ.size()), {8{$urandom}}, 1'b0);
    end

    // Abort while the core works on a full, non-final block.
    coreDelay = 8;
    for (int wi = 0; wi < RATE_WORDS; wi++) sendWord($urandom, 1'b0, 3'd4);
    bus.msg_valid_i = 1'b0;
    checkOutput("abort pre start", {255'd0, bus.core_start_o}, 256'd1);
    @(negedge clk);
    abortMode   = 1'b1;
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    checkOutput("drain busy", {255'd0, bus.busy_o}, 256'd1);
    checkOutput("drain ready", {255'd0, bus.msg_ready_o}, 256'd0);
    checkOutput("drain blocks", 256'(bus.blocks_o), 256'd0);
    checkOutput("drain digest_valid", {255'd0, bus.digest_valid_o}, 256'd0);
    checkOutput("drain buffer cleared", chunk(bus.core_block_o, 0), 256'd0);
    n = 0;
    sawStart = 1'b0;
    while (!bus.core_done_i && n < 100) begin
      if (bus.core_start_o) sawStart = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeoutFail("drain done");
    checkOutput("no start in drain", {255'd0, sawStart}, 256'd0);
    @(negedge clk);
    checkOutput("after drain busy", {255'd0, bus.busy_o}, 256'd0);
    checkOutput("after drain ready", {255'd0, bus.msg_ready_o}, 256'd1);
    checkOutput("after drain digest_valid", {255'd0, bus.digest_valid_o}, 256'd0);
    checkOutput("after drain blocks", 256'(bus.blocks_o), 256'd0);
    abortMode = 1'b0;
    coreDelay = 0;

    // Asynchronous reset in the middle of filling a block.
    for (int wi = 0; wi < 5; wi++) sendWord($urandom, 1'b0, 3'd4);
    bus.msg_valid_i = 1'b0;
    checkOutput("fill busy", {255'd0, bus.busy_o}, 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {255'd0, bus.busy_o}, 256'd0);
    checkOutput("async reset digest", bus.digest_o, 256'd0);
    checkOutput("async reset block", chunk(bus.core_block_o, 0), 256'd0);
    checkOutput("async reset blocks", 256'(bus.blocks_o), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    msgQ.delete();
    msgQ.push_back(8'h61);
    msgQ.push_back(8'h62);
    msgQ.push_back(8'h63);
    applyStimulus("abc after reset", SHA3_256_ABC, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
